parse_message: RTL and testbench

- Receive-side counterpart of the FIX message builder.
- Consumes an inbound FIX byte stream (one ASCII byte per cycle) and parses the `tag=value<SOH>` fields.
- Extracts the administrative header and body fields, then checks BodyLength and CheckSum.
- Presents a decoded message, in the same field formats the builder consumes, to the session layer, or flags an error.

---
 rtl/fix_pkg.sv | 65 ++++++
 rtl/fix_checksum_acc.sv | 38 +++
 rtl/parse_message.sv | 274 +++++++++++++++++++++++++++
 tb/tb_parse_message.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// fix_pkg: shared FIX protocol constants for the receive-side parser.
// Holds the SOH/ASCII byte constants, the tag numbers the parser routes on,
// message-type and error codes, the parser FSM state enum and small
// byte-classification helpers.
package fix_pkg;

  // Field delimiter and ASCII bytes the parser reacts to
  localparam logic [7:0] SOH       = 8'h01;
  localparam logic [7:0] ASCII_EQ  = 8'h3D;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_2   = 8'h32;
  localparam logic [7:0] ASCII_5   = 8'h35;
  localparam logic [7:0] ASCII_8   = 8'h38;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_A   = 8'h41;

  // Tag numbers (10-bit tag accumulator)
  localparam logic [9:0] TAG_BEGIN    = 10'd8;
  localparam logic [9:0] TAG_BODYLEN  = 10'd9;
  localparam logic [9:0] TAG_CHECKSUM = 10'd10;
  localparam logic [9:0] TAG_SEQNUM   = 10'd34;
  localparam logic [9:0] TAG_MSGTYPE  = 10'd35;
  localparam logic [9:0] TAG_SENDER   = 10'd49;
  localparam logic [9:0] TAG_TARGET   = 10'd56;
  localparam logic [9:0] TAG_HBINT    = 10'd108;

  // Decoded message types, same encoding the builder consumes
  localparam logic [2:0] MSG_OTHER     = 3'b000;
  localparam logic [2:0] MSG_LOGON     = 3'b001;
  localparam logic [2:0] MSG_LOGOUT    = 3'b010;
  localparam logic [2:0] MSG_HEARTBEAT = 3'b011;
  localparam logic [2:0] MSG_SEQREQ    = 3'b100;

  // Error codes
  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_BAD_TAG      = 3'd1;
  localparam logic [2:0] ERR_BAD_HEADER   = 3'd2;
  localparam logic [2:0] ERR_BAD_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_OVERLONG     = 3'd4;
  localparam logic [2:0] ERR_BAD_LENGTH   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TAG   = 2'd1,
    ST_VALUE = 2'd2,
    ST_SKIP  = 2'd3
  } state_t;

  function automatic logic isDigit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic [2:0] decodeMsgType(input logic [7:0] b);
    logic [2:0] t;
    case (b)
      ASCII_A: t = MSG_LOGON;
      ASCII_5: t = MSG_LOGOUT;
      ASCII_0: t = MSG_HEARTBEAT;
      ASCII_2: t = MSG_SEQREQ;
      default: t = MSG_OTHER;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fix_checksum_acc.sv
// fix_checksum_acc: running modulo-256 byte sum with load and snapshot.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              a byte is consumed this cycle
//   load            restart the sum with dataByte (first byte of a message)
//   snap            capture the sum of all bytes before dataByte
//   dataByte        byte being consumed
//   snapshot        last captured sum
module fix_checksum_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic       snap,
  input  logic [7:0] dataByte,
  output logic [7:0] snapshot
);

  logic [7:0] sum_r;

  // Accumulate consumed bytes; the snapshot takes the sum before the current byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r    <= 8'd0;
      snapshot <= 8'd0;
    end else if (en) begin
      if (load) begin
        sum_r <= dataByte;
      end else begin
        sum_r <= sum_r + dataByte;
      end
      if (snap) begin
        snapshot <= sum_r;
      end
    end
  end

endmodule

// File: rtl/parse_message.sv
// parse_message: receive-side FIX parser.
// Consumes one ASCII byte per accepted cycle, splits tag=value<SOH> fields,
// checks header order, BodyLength (9) and CheckSum (10), and presents the
// decoded administrative fields or an error code to the session layer.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   data_valid_i, data_i             inbound byte stream (valid low = stall)
//   message_valid_o                  one-cycle pulse, good message decoded
//   message_type_o                   decoded tag 35 type
//   senderCompId_o / sizeSenderId_o  tag 49 chars (last char in [7:0]) / count
//   targetCompId_o / sizeTargetId_o  tag 56 chars / count
//   msgSeqNum_o, heartBeatInt_o      tags 34 and 108, binary
//   checksum_o                       computed checksum of last completed message
//   error_o, error_code_o            one-cycle error pulse, code held
module parse_message
  import fix_pkg::*;
#(
  parameter int VALUE_WIDTH  = 256,
  parameter int WIDTH_SIZE   = 5,
  parameter int SEQMEM_DEPTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_valid_i,
  input  logic [7:0]              data_i,
  output logic                    message_valid_o,
  output logic [2:0]              message_type_o,
  output logic [VALUE_WIDTH-1:0]  senderCompId_o,
  output logic [VALUE_WIDTH-1:0]  targetCompId_o,
  output logic [WIDTH_SIZE-1:0]   sizeSenderId_o,
  output logic [WIDTH_SIZE-1:0]   sizeTargetId_o,
  output logic [SEQMEM_DEPTH-1:0] msgSeqNum_o,
  output logic [7:0]              heartBeatInt_o,
  output logic [7:0]              checksum_o,
  output logic                    error_o,
  output logic [2:0]              error_code_o
);

  state_t                  state_r;
  logic                    atBoundary_r;
  logic [9:0]              tag_r;
  logic                    hasDigit_r;
  logic [1:0]              fieldIdx_r;
  logic [11:0]             bodyLen_r;
  logic [11:0]             bodyCnt_r;
  logic [11:0]             bodyCntSnap_r;
  logic                    countEn_r;
  logic                    firstValue_r;
  logic [2:0]              msgType_r;
  logic [SEQMEM_DEPTH-1:0] seq_r;
  logic [7:0]              hb_r;
  logic [VALUE_WIDTH-1:0]  sender_r;
  logic [VALUE_WIDTH-1:0]  target_r;
  logic [WIDTH_SIZE-1:0]   sizeS_r;
  logic [WIDTH_SIZE-1:0]   sizeT_r;
  logic [9:0]              rxChecksum_r;

  logic                    isDigit_s;
  logic [3:0]              digit_s;
  logic                    load_s;
  logic                    snap_s;
  logic [7:0]              accSnap_s;

  localparam logic [WIDTH_SIZE-1:0] SIZE_MAX = {WIDTH_SIZE{1'b1}};

  // Byte classification and checksum-accumulator controls
  always_comb begin
    isDigit_s = isDigit(data_i);
    // ASCII digits carry their value in the low nibble
    digit_s   = data_i[3:0];
    load_s    = data_valid_i && (state_r == ST_IDLE) && (data_i == ASCII_8) && atBoundary_r;
    // The first digit of every tag captures the sum and body count; the
    // capture made at the start of tag 10 is the one that gets checked.
    if (data_valid_i && (state_r == ST_TAG) && !hasDigit_r && isDigit_s) begin
      snap_s = 1'b1;
    end else begin
      snap_s = 1'b0;
    end
  end

  fix_checksum_acc uAcc (
    .clk      (clk),
    .rst      (rst),
    .en       (data_valid_i),
    .load     (load_s),
    .snap     (snap_s),
    .dataByte (data_i),
    .snapshot (accSnap_s)
  );

  // Parser FSM with per-message accumulators and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      atBoundary_r    <= 1'b1;
      tag_r           <= 10'd0;
      hasDigit_r      <= 1'b0;
      fieldIdx_r      <= 2'd0;
      bodyLen_r       <= 12'd0;
      bodyCnt_r       <= 12'd0;
      bodyCntSnap_r   <= 12'd0;
      countEn_r       <= 1'b0;
      firstValue_r    <= 1'b0;
      msgType_r       <= MSG_OTHER;
      seq_r           <= '0;
      hb_r            <= 8'd0;
      sender_r        <= '0;
      target_r        <= '0;
      sizeS_r         <= '0;
      sizeT_r         <= '0;
      rxChecksum_r    <= 10'd0;
      message_valid_o <= 1'b0;
      message_type_o  <= MSG_OTHER;
      senderCompId_o  <= '0;
      targetCompId_o  <= '0;
      sizeSenderId_o  <= '0;
      sizeTargetId_o  <= '0;
      msgSeqNum_o     <= '0;
      heartBeatInt_o  <= 8'd0;
      checksum_o      <= 8'd0;
      error_o         <= 1'b0;
      error_code_o    <= ERR_NONE;
    end else begin
      message_valid_o <= 1'b0;
      error_o         <= 1'b0;
      if (data_valid_i) begin
        atBoundary_r <= (data_i == SOH);
        if (countEn_r) begin
          bodyCnt_r <= bodyCnt_r + 12'd1;
        end
        case (state_r)
          ST_IDLE: begin
            if ((data_i == ASCII_8) && atBoundary_r) begin
              tag_r        <= TAG_BEGIN;
              hasDigit_r   <= 1'b1;
              fieldIdx_r   <= 2'd0;
              bodyLen_r    <= 12'd0;
              bodyCnt_r    <= 12'd0;
              bodyCntSnap_r <= 12'd0;
              countEn_r    <= 1'b0;
              msgType_r    <= MSG_OTHER;
              seq_r        <= '0;
              hb_r         <= 8'd0;
              sender_r     <= '0;
              target_r     <= '0;
              sizeS_r      <= '0;
              sizeT_r      <= '0;
              rxChecksum_r <= 10'd0;
              state_r      <= ST_TAG;
            end
          end
          ST_TAG: begin
            if (isDigit_s) begin
              tag_r      <= tag_r * 10'd10 + {6'd0, digit_s};
              hasDigit_r <= 1'b1;
              if (!hasDigit_r) begin
                bodyCntSnap_r <= bodyCnt_r;
              end
            end else if ((data_i == ASCII_EQ) && hasDigit_r) begin
              if (((fieldIdx_r == 2'd0) && (tag_r != TAG_BEGIN)) ||
                  ((fieldIdx_r == 2'd1) && (tag_r != TAG_BODYLEN))) begin
                error_o      <= 1'b1;
                error_code_o <= ERR_BAD_HEADER;
                state_r      <= ST_IDLE;
              end else begin
                firstValue_r <= 1'b1;
                state_r      <= ST_VALUE;
                if (fieldIdx_r != 2'd2) begin
                  fieldIdx_r <= fieldIdx_r + 2'd1;
                end
              end
            end else begin
              error_o      <= 1'b1;
              error_code_o <= ERR_BAD_TAG;
              state_r      <= ST_IDLE;
            end
          end
          ST_VALUE: begin
            if (data_i == SOH) begin
              if (tag_r == TAG_CHECKSUM) begin
                checksum_o <= accSnap_s;
                countEn_r  <= 1'b0;
                state_r    <= ST_IDLE;
                if (bodyCntSnap_r != bodyLen_r) begin
                  error_o      <= 1'b1;
                  error_code_o <= ERR_BAD_LENGTH;
                end else if (rxChecksum_r != {2'd0, accSnap_s}) begin
                  error_o      <= 1'b1;
                  error_code_o <= ERR_BAD_CHECKSUM;
                end else begin
                  message_valid_o <= 1'b1;
                  message_type_o  <= msgType_r;
                  senderCompId_o  <= sender_r;
                  targetCompId_o  <= target_r;
                  sizeSenderId_o  <= sizeS_r;
                  sizeTargetId_o  <= sizeT_r;
                  msgSeqNum_o     <= seq_r;
                  heartBeatInt_o  <= hb_r;
                end
              end else begin
                // Body bytes are counted from the byte after BodyLength's SOH
                if (tag_r == TAG_BODYLEN) begin
                  bodyCnt_r <= 12'd0;
                  countEn_r <= 1'b1;
                end
                tag_r      <= 10'd0;
                hasDigit_r <= 1'b0;
                state_r    <= ST_TAG;
              end
            end else begin
              firstValue_r <= 1'b0;
              case (tag_r)
                TAG_BODYLEN: begin
                  if (isDigit_s) begin
                    bodyLen_r <= bodyLen_r * 12'd10 + {8'd0, digit_s};
                  end
                end
                TAG_MSGTYPE: begin
                  if (firstValue_r) begin
                    msgType_r <= decodeMsgType(data_i);
                  end
                end
                TAG_SEQNUM: begin
                  if (isDigit_s) begin
                    seq_r <= seq_r * SEQMEM_DEPTH'(4'd10) + SEQMEM_DEPTH'(digit_s);
                  end
                end
                TAG_HBINT: begin
                  if (isDigit_s) begin
                    hb_r <= hb_r * 8'd10 + {4'd0, digit_s};
                  end
                end
                TAG_SENDER: begin
                  if (sizeS_r == SIZE_MAX) begin
                    error_o      <= 1'b1;
                    error_code_o <= ERR_OVERLONG;
                    state_r      <= ST_IDLE;
                  end else begin
                    sender_r <= {sender_r[VALUE_WIDTH-9:0], data_i};
                    sizeS_r  <= sizeS_r + WIDTH_SIZE'(1'b1);
                  end
                end
                TAG_TARGET: begin
                  if (sizeT_r == SIZE_MAX) begin
                    error_o      <= 1'b1;
                    error_code_o <= ERR_OVERLONG;
                    state_r      <= ST_IDLE;
                  end else begin
                    target_r <= {target_r[VALUE_WIDTH-9:0], data_i};
                    sizeT_r  <= sizeT_r + WIDTH_SIZE'(1'b1);
                  end
                end
                TAG_CHECKSUM: begin
                  if (isDigit_s) begin
                    rxChecksum_r <= rxChecksum_r * 10'd10 + {6'd0, digit_s};
                  end
                end
                default: begin
                end
              endcase
            end
          end
          ST_SKIP: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parse_message.sv
// tb_parse_message: scoreboard bench for parse_message. The driver streams
// directed FIX frames ('|' stands for SOH) and pushes the expected response,
// including the cycle it must appear in; a monitor pops and compares on
// every message_valid_o / error_o pulse.
module tb_parse_message;

  logic         clk;
  logic         rst;
  logic         data_valid_i;
  logic [7:0]   data_i;
  logic         message_valid_o;
  logic [2:0]   message_type_o;
  logic [255:0] senderCompId_o;
  logic [255:0] targetCompId_o;
  logic [4:0]   sizeSenderId_o;
  logic [4:0]   sizeTargetId_o;
  logic [9:0]   msgSeqNum_o;
  logic [7:0]   heartBeatInt_o;
  logic [7:0]   checksum_o;
  logic         error_o;
  logic [2:0]   error_code_o;

  parse_message #(.VALUE_WIDTH(256), .WIDTH_SIZE(5), .SEQMEM_DEPTH(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_valid_i    (data_valid_i),
    .data_i          (data_i),
    .message_valid_o (message_valid_o),
    .message_type_o  (message_type_o),
    .senderCompId_o  (senderCompId_o),
    .targetCompId_o  (targetCompId_o),
    .sizeSenderId_o  (sizeSenderId_o),
    .sizeTargetId_o  (sizeTargetId_o),
    .msgSeqNum_o     (msgSeqNum_o),
    .heartBeatInt_o  (heartBeatInt_o),
    .checksum_o      (checksum_o),
    .error_o         (error_o),
    .error_code_o    (error_code_o)
  );

  typedef struct {
    bit           isErr;
    logic [2:0]   code;
    logic [2:0]   mtype;
    logic [255:0] snd;
    logic [255:0] tgt;
    logic [4:0]   ss;
    logic [4:0]   st;
    logic [9:0]   seq;
    logic [7:0]   hb;
    logic [7:0]   cs;
    int           cyc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   negCnt = 0;
  int   validSeen = 0;

  // Model of the held output state
  logic [2:0]   gType;
  logic [255:0] gSnd, gTgt;
  logic [4:0]   gSs, gSt;
  logic [9:0]   gSeq;
  logic [7:0]   gHb, gCs;
  logic [2:0]   gCode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exq);
    checks++;
    if (act !== exq) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exq);
    end
  endfunction

  function automatic void modelReset();
    gType = 3'd0; gSnd = '0; gTgt = '0; gSs = 5'd0; gSt = 5'd0;
    gSeq = 10'd0; gHb = 8'd0; gCs = 8'd0; gCode = 3'd0;
  endfunction

  function automatic exp_t expGood(input logic [2:0] mt, input logic [255:0] snd,
                                   input logic [255:0] tgt, input logic [4:0] ss,
                                   input logic [4:0] st, input logic [9:0] seq,
                                   input logic [7:0] hb, input logic [7:0] cs);
    exp_t e;
    gType = mt; gSnd = snd; gTgt = tgt; gSs = ss; gSt = st;
    gSeq = seq; gHb = hb; gCs = cs;
    e.isErr = 1'b0; e.code = gCode; e.mtype = mt; e.snd = snd; e.tgt = tgt;
    e.ss = ss; e.st = st; e.seq = seq; e.hb = hb; e.cs = cs; e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t expErr(input logic [2:0] code, input bit csUpd, input logic [7:0] cs);
    exp_t e;
    if (csUpd) gCs = cs;
    gCode = code;
    e.isErr = 1'b1; e.code = code; e.mtype = gType; e.snd = gSnd; e.tgt = gTgt;
    e.ss = gSs; e.st = gSt; e.seq = gSeq; e.hb = gHb; e.cs = gCs; e.cyc = 0;
    return e;
  endfunction

  function automatic logic [7:0] toByte(input logic [7:0] c);
    return (c == 8'h7C) ? 8'h01 : c;
  endfunction

  function automatic logic [7:0] sumStr(input string s);
    logic [7:0] acc = 8'd0;
    for (int i = 0; i < s.len(); i++) acc = acc + toByte(s[i]);
    return acc;
  endfunction

  // Stream a frame; the byte at index trig is the one that must produce e
  task automatic sendStr(input string s, input int trig, input exp_t e, input int maxGap);
    for (int i = 0; i < s.len(); i++) begin
      if (maxGap > 0) begin
        int g;
        g = $urandom_range(maxGap, 0);
        repeat (g) begin
          data_valid_i = 1'b0;
          data_i = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      data_valid_i = 1'b1;
      data_i = toByte(s[i]);
      if (i == trig) begin
        e.cyc = negCnt + 2;
        expQ.push_back(e);
      end
      @(posedge clk); #1;
    end
    data_valid_i = 1'b0;
    data_i = 8'h00;
  endtask

  task automatic checkResetOutputs();
    chk("rst_valid", message_valid_o, 1'b0);
    chk("rst_type", message_type_o, 3'd0);
    chk("rst_sender", senderCompId_o, 256'd0);
    chk("rst_target", targetCompId_o, 256'd0);
    chk("rst_sizes", {sizeSenderId_o, sizeTargetId_o}, 10'd0);
    chk("rst_seq", msgSeqNum_o, 10'd0);
    chk("rst_hb", heartBeatInt_o, 8'd0);
    chk("rst_checksum", checksum_o, 8'd0);
    chk("rst_error", {error_o, error_code_o}, 4'd0);
  endtask

  // Monitor: compare every output pulse against the scoreboard head
  always @(negedge clk) begin
    negCnt++;
    if (!rst && (message_valid_o || error_o)) begin
      if (message_valid_o) validSeen++;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event valid=%0d err=%0d code=%0d", message_valid_o, error_o, error_code_o);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("latency", negCnt, e.cyc);
        chk("valid", message_valid_o, !e.isErr);
        chk("error", error_o, e.isErr);
        chk("error_code", error_code_o, e.code);
        chk("type", message_type_o, e.mtype);
        chk("sender", senderCompId_o, e.snd);
        chk("target", targetCompId_o, e.tgt);
        chk("size_sender", sizeSenderId_o, e.ss);
        chk("size_target", sizeTargetId_o, e.st);
        chk("seqnum", msgSeqNum_o, e.seq);
        chk("hbint", heartBeatInt_o, e.hb);
        chk("checksum", checksum_o, e.cs);
      end
    end
  end

  initial begin
    string hb, body, frame, full, longId, ovl;
    logic [7:0] cs;
    exp_t noExp;
    noExp = '{default: 0};
    modelReset();
    hb = "8=FIX.4.2|9=5|35=0|10=161|";
    rst = 1'b1;
    data_valid_i = 1'b0;
    data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkResetOutputs();

    // Heartbeat, no stalls
    sendStr(hb, hb.len() - 1, expGood(3'b011, 256'd0, 256'd0, 5'd0, 5'd0, 10'd0, 8'd0, 8'd161), 0);

    // Logon with bench-computed BodyLength and CheckSum
    body = "35=A|34=7|49=AB|56=CD|108=30|";
    frame = {"8=FIX.4.2|9=", $sformatf("%0d", body.len()), "|", body};
    cs = sumStr(frame);
    full = {frame, $sformatf("10=%03d|", cs)};
    sendStr(full, full.len() - 1,
            expGood(3'b001, 256'h4142, 256'h4344, 5'd2, 5'd2, 10'd7, 8'd30, cs), 0);

    // Bad checksum, bad length, bad tag, bad header
    sendStr("8=FIX.4.2|9=5|35=0|10=162|", 25, expErr(3'd3, 1'b1, 8'd161), 0);
    sendStr("8=FIX.4.2|9=6|35=0|10=161|", 25, expErr(3'd5, 1'b1, 8'd162), 0);
    sendStr("8=FIX.4.2|X=1|35=0|10=161|", 10, expErr(3'd1, 1'b0, 8'd0), 0);
    sendStr("8=FIX.4.2|35=0|10=161|", 12, expErr(3'd2, 1'b0, 8'd0), 0);

    // No start: first tag 9
    sendStr("9=5|35=0|10=161|", -1, noExp, 0);

    // 32-character sender id, then a clean heartbeat
    longId = "ABCDEFGHIJKLMNOPQRSTUVWXYZABCDEF";
    ovl = {"8=FIX.4.2|9=40|49=", longId, "|10=000|"};
    sendStr(ovl, 18 + 31, expErr(3'd4, 1'b0, 8'd0), 0);
    sendStr(hb, hb.len() - 1, expGood(3'b011, 256'd0, 256'd0, 5'd0, 5'd0, 10'd0, 8'd0, 8'd161), 0);

    // Heartbeat with random stalls
    sendStr(hb, hb.len() - 1, expGood(3'b011, 256'd0, 256'd0, 5'd0, 5'd0, 10'd0, 8'd0, 8'd161), 3);

    // Reset mid-body, then a clean heartbeat
    sendStr("8=FIX.4.2|9=5|35", -1, noExp, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    @(posedge clk); #1;
    checkResetOutputs();
    sendStr(hb, hb.len() - 1, expGood(3'b011, 256'd0, 256'd0, 5'd0, 5'd0, 10'd0, 8'd0, 8'd161), 0);

    repeat (20) @(posedge clk);
    #1;
    chk("queue_drained", expQ.size(), 0);
    chk("valid_pulses", validSeen, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
